// File: rtl/target_cmd_pkg.sv
// Shared types and defaults for the ground-link target command decoder.
// Parser/UART state encodings, frame markers and payload sizing.
package target_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MODE,
    ST_PAYLOAD,
    ST_CHK,
    ST_LSTOP,
    ST_SSTOP
  } parse_st_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_st_t;

  localparam logic [7:0] START_BYTE_DEF = 8'h0A;
  localparam logic [7:0] STOP_BYTE_DEF  = 8'h08;
  localparam int MODE_SETPOINT_BIT = 7;

  function automatic int payload_bytes(
    input int n_ch,
    input int ch_w
  );
    return n_ch * ch_w / 8;
  endfunction

endpackage

// File: rtl/target_cmd_decoder_uart_rx.sv
// 8N1 UART receiver with 2-flop synchroniser and mid-bit sampling.
// Start bit is re-checked at half a bit to reject line glitches.
module uart_rx_core
  import target_cmd_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       rx_ferr
);

  localparam int DIV  = CLK_HZ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV) + 1;

  logic          rx_s1;
  logic          rx_s2;
  logic          rx_prev;
  rx_st_t        st;
  logic [CW-1:0] cnt;
  logic [2:0]    bitn;
  logic [7:0]    sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_prev    <= 1'b1;
      st         <= RX_IDLE;
      cnt        <= '0;
      bitn       <= '0;
      sh         <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      rx_ferr    <= 1'b0;
    end else begin
      rx_s1      <= rxd;
      rx_s2      <= rx_s1;
      rx_prev    <= rx_s2;
      byte_valid <= 1'b0;
      rx_ferr    <= 1'b0;
      unique case (st)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            st  <= RX_START;
            cnt <= '0;
          end
        end
        RX_START: begin
          if (cnt == CW'(HALF - 1)) begin
            cnt  <= '0;
            bitn <= '0;
            st   <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (cnt == CW'(DIV - 1)) begin
            cnt <= '0;
            sh  <= {rx_s2, sh[7:1]};
            if (bitn == 3'd7) begin
              st <= RX_STOP;
            end else begin
              bitn <= bitn + 3'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (cnt == CW'(DIV - 1)) begin
            cnt <= '0;
            st  <= RX_IDLE;
            if (rx_s2) begin
              rx_byte    <= sh;
              byte_valid <= 1'b1;
            end else begin
              rx_ferr <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: st <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/target_cmd_decoder.sv
// Ground-link command decoder: legacy action frames and checksummed
// setpoint frames, published atomically to the PID stage.
module target_cmd_decoder
  import target_cmd_pkg::*;
#(
  parameter int         CLK_HZ      = 50_000_000,
  parameter int         BAUD        = 115200,
  parameter int         N_CH        = 4,
  parameter int         CH_W        = 16,
  parameter logic [7:0] START_BYTE  = START_BYTE_DEF,
  parameter logic [7:0] STOP_BYTE   = STOP_BYTE_DEF,
  parameter int         TIMEOUT_CYC = 1_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RxD,
  output logic                 target_renew,
  output logic [N_CH*CH_W-1:0] target_data,
  output logic                 action_valid,
  output logic [6:0]           action_code,
  output logic                 err_chk,
  output logic                 err_frame,
  output logic                 err_timeout,
  output logic [7:0]           err_cnt,
  output logic                 rx_busy
);

  localparam int N_BYTES = payload_bytes(N_CH, CH_W);
  localparam int DW      = N_CH * CH_W;
  localparam int IW      = $clog2(N_BYTES + 1);
  localparam int TW      = $clog2(TIMEOUT_CYC + 1);

  logic [7:0]    rx_byte;
  logic          byte_valid;
  logic          rx_ferr;

  parse_st_t     state;
  logic [DW-1:0] shadow;
  logic [6:0]    shadow_code;
  logic [7:0]    chk;
  logic [IW-1:0] idx;
  logic [TW-1:0] tmo_cnt;

  uart_rx_core #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rxd        (RxD),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .rx_ferr    (rx_ferr)
  );

  assign rx_busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      shadow       <= '0;
      shadow_code  <= '0;
      chk          <= '0;
      idx          <= '0;
      tmo_cnt      <= '0;
      target_renew <= 1'b0;
      target_data  <= '0;
      action_valid <= 1'b0;
      action_code  <= '0;
      err_chk      <= 1'b0;
      err_frame    <= 1'b0;
      err_timeout  <= 1'b0;
      err_cnt      <= '0;
    end else begin
      // pulses from the previous cycle feed the saturating counter
      if ((err_chk || err_frame || err_timeout) && err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end
      target_renew <= 1'b0;
      action_valid <= 1'b0;
      err_chk      <= 1'b0;
      err_frame    <= 1'b0;
      err_timeout  <= 1'b0;

      if (byte_valid) begin
        tmo_cnt <= '0;
        unique case (state)
          ST_IDLE: begin
            if (rx_byte == START_BYTE) state <= ST_MODE;
          end
          ST_MODE: begin
            if (!rx_byte[MODE_SETPOINT_BIT]) begin
              shadow_code <= rx_byte[6:0];
              state       <= ST_LSTOP;
            end else begin
              chk   <= rx_byte;
              idx   <= '0;
              state <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            shadow[{idx, 3'b000} +: 8] <= rx_byte;
            chk <= chk ^ rx_byte;
            if (idx == IW'(N_BYTES - 1)) begin
              state <= ST_CHK;
            end else begin
              idx <= idx + IW'(1);
            end
          end
          ST_CHK: begin
            if (rx_byte != chk) begin
              err_chk <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              state <= ST_SSTOP;
            end
          end
          ST_LSTOP: begin
            if (rx_byte == STOP_BYTE) begin
              action_code  <= shadow_code;
              action_valid <= 1'b1;
            end else begin
              err_frame <= 1'b1;
            end
            state <= ST_IDLE;
          end
          ST_SSTOP: begin
            if (rx_byte == STOP_BYTE) begin
              target_data  <= shadow;
              target_renew <= 1'b1;
            end else begin
              err_frame <= 1'b1;
            end
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end else if (rx_ferr) begin
        err_frame <= 1'b1;
        state     <= ST_IDLE;
        tmo_cnt   <= '0;
      end else if (state != ST_IDLE) begin
        if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
          err_timeout <= 1'b1;
          state       <= ST_IDLE;
          tmo_cnt     <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + TW'(1);
        end
      end
    end
  end

endmodule
